// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - Booth digit/state types and the radix-4 recoding function
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - partial-product select: 0, +/-a or +/-2a of the extended multiplicand
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int AW = 34
) (
  input  booth_digit_t    digit,
  input  logic [AW-1:0]   mcand,
  output logic [AW-1:0]   pp
);

  logic [AW-1:0] mag;
  logic          neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (digit)
      POS1: mag = mcand;
      POS2: mag = mcand << 1;
      NEG1: begin mag = mcand;      neg = 1'b1; end
      NEG2: begin mag = mcand << 1; neg = 1'b1; end
      default: mag = '0;
    endcase
    // Negation as invert-plus-one, matching the parallel array's convention.
    pp = neg ? (~mag + AW'(1)) : mag;
  end

endmodule

// File: rtl/booth_serial_mult.sv
// rtl/booth_serial_mult.sv - iterative radix-4 Booth multiplier, one digit per clock
module booth_serial_mult
  import booth_pkg::*;
#(
  parameter int    W      = 16,
  parameter string SIGNED = "TRUE"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam bit IS_SIGNED = (SIGNED == "TRUE");
  localparam int N         = IS_SIGNED ? W / 2 : W / 2 + 1;
  localparam int AW        = 2 * W + 2;
  localparam int BW        = W + 3;
  localparam int CW        = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  booth_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, acc_next, a_sh, pp;
  logic [BW-1:0] b_sh;
  logic          a_fill, b_fill;
  booth_digit_t  digit;

  assign a_fill = IS_SIGNED & a[W-1];
  assign b_fill = IS_SIGNED & b[W-1];

  // b_sh holds {ext, ext, b, b[-1]=0}; its low triplet is always the current digit.
  assign digit    = booth_recode(b_sh[2:0]);
  assign acc_next = acc + pp;

  booth_pp_sel #(.AW(AW)) u_pp_sel (
    .digit (digit),
    .mcand (a_sh),
    .pp    (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Multiplicand shifts left by 2 per digit instead of a 2i barrel shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      p    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= {{(AW-W){a_fill}}, a};
          b_sh <= {b_fill, b_fill, b, 1'b0};
          acc  <= '0;
          cnt  <= '0;
        end
        RUN: begin
          acc  <= acc_next;
          a_sh <= a_sh << 2;
          b_sh <= {b_sh[BW-1], b_sh[BW-1], b_sh[BW-1:2]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) p <= acc_next[2*W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_serial_mult.sv
// tb/tb_booth_serial_mult.sv - self-checking bench for signed and unsigned booth_serial_mult
module tb_booth_serial_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] a_i       [2];
  logic [15:0] b_i       [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] p_o       [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_serial_mult #(.W(16), .SIGNED("TRUE")) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[0]), .b(b_i[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .p(p_o[0])
  );

  booth_serial_mult #(.W(16), .SIGNED("FALSE")) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i[1]), .b(b_i[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .p(p_o[1])
  );

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int d, input logic [15:0] x, input logic [15:0] y);
    longint px;
    if (d == 0) px = longint'($signed(x)) * longint'($signed(y));
    else        px = longint'(x) * longint'(y);
    return px[31:0];
  endfunction

  function automatic int lat_exp(input int d);
    return (d == 0) ? 9 : 10;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one pair, wait for the product, release it after 'hold' stalled cycles.
  task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, output logic [31:0] got, output int lat);
    check("in_ready_at_issue", 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1;
    a_i[d] = av;
    b_i[d] = bv;
    @(negedge clk);
    in_valid[d] = 1'b0;
    a_i[d] = 16'($urandom);
    b_i[d] = 16'($urandom);
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 40) begin
      out_ready[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready[d] = 1'b0;
    got = p_o[d];
    repeat (hold) @(negedge clk);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("out_valid_after_hs", 64'(out_valid[d]), 64'd0);
    check("in_ready_after_hs", 64'(in_ready[d]), 64'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] got, held;
    int          lat;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", 64'(in_ready[i]), 64'd1);
      check("reset_out_valid", 64'(out_valid[i]), 64'd0);
      check("reset_p", 64'(p_o[i]), 64'd0);
    end

    vecs.push_back('{0, 16'd3,    16'd5,    32'h0000000F});
    vecs.push_back('{0, 16'h8000, 16'h8000, 32'h40000000});
    vecs.push_back('{0, 16'hFFFF, 16'h0001, 32'hFFFFFFFF});
    vecs.push_back('{1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{1, 16'h8000, 16'h0002, 32'h00010000});
    vecs.push_back('{0, 16'd7,    16'hFFFE, 32'hFFFFFFF2});
    vecs.push_back('{0, 16'h0000, 16'h0000, 32'h00000000});
    vecs.push_back('{1, 16'h0000, 16'hFFFF, 32'h00000000});
    vecs.push_back('{0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001});
    vecs.push_back('{0, 16'h8000, 16'h7FFF, 32'hC0008000});
    vecs.push_back('{1, 16'hFFFF, 16'h0001, 32'h0000FFFF});
    foreach (vecs[k]) begin
      run_op(vecs[k].d, vecs[k].a, vecs[k].b, 0, got, lat);
      check($sformatf("vec%0d_p", k), 64'(got), 64'(vecs[k].exp));
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'(lat_exp(vecs[k].d)));
    end

    // Backpressure: product held 20 cycles while a second pair is offered and ignored.
    in_valid[0] = 1'b1; a_i[0] = 16'h1234; b_i[0] = 16'h0056;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (out_valid[0] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("bp_latency", 64'(lat), 64'd9);
    held = p_o[0];
    check("bp_p", 64'(held), 64'(model(0, 16'h1234, 16'h0056)));
    in_valid[0] = 1'b1; a_i[0] = 16'h0101; b_i[0] = 16'h0202;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_p_stable", 64'(p_o[0]), 64'(held));
      check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_in_ready_return", 64'(in_ready[0]), 64'd1);
    repeat (3) @(negedge clk);
    check("bp_no_queued_op", 64'(out_valid[0]), 64'd0);
    check("bp_idle_in_ready", 64'(in_ready[0]), 64'd1);

    // Reset during the 4th RUN cycle discards the partial result.
    in_valid[0] = 1'b1; a_i[0] = 16'h1111; b_i[0] = 16'h2222;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_mid_p", 64'(p_o[0]), 64'd0);
    check("rst_mid_p_unsigned", 64'(p_o[1]), 64'd0);
    run_op(0, 16'd7, 16'hFFFE, 1, got, lat);
    check("rst_after_p", 64'(got), 64'hFFFFFFF2);
    check("rst_after_latency", 64'(lat), 64'd9);

    // Randomized pairs and handshake gaps against the arithmetic model.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 1500; k++) begin
        logic [15:0] ra, rb;
        ra = pick_operand();
        rb = pick_operand();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(d, ra, rb, $urandom_range(0, 3), got, lat);
        check("rand_p", 64'(got), 64'(model(d, ra, rb)));
        check("rand_latency", 64'(lat), 64'(lat_exp(d)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
